// File: rtl/uart_rx_osr.sv
// uart_rx_osr: oversampled UART receiver for the echo path.
//   Synchronises rxd, detects the start bit on the sample_tick grid, samples
//   each bit at its centre and hands the byte over a valid/ack handshake.
//   Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit whose
//   mismatch is ORed into frame_err).
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   sample_tick  one-clk enable at OSR x baud; all bit timing advances on it
//   rxd          asynchronous serial input, idle high
//   rx_data      received byte, LSB first on the line
//   rx_valid     rx_data holds an unacknowledged byte
//   rx_ack       one-clk consumer pulse, clears rx_valid and overrun_err
//   frame_err    stop bit (or parity) bad on the last frame
//   overrun_err  a frame completed while rx_valid was still set
//   busy         receiver is inside a frame
module uart_rx_osr #(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_HALF_LAST = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] T_FULL_LAST = TW'(OSR - 1);
    localparam logic [TW-1:0] T_ONE       = TW'(1);
    localparam logic [BW-1:0] B_LAST      = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_ONE       = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [TW-1:0]        r_tcnt;
    logic [BW-1:0]        r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun_err;
    logic                 r_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_err;
`endif

    logic w_rxs;
    logic w_half;
    logic w_full;
    logic w_done;
    logic w_frame_bad;

    assign w_rxs  = r_sync2;
    assign w_half = (r_tcnt == T_HALF_LAST);
    assign w_full = (r_tcnt == T_FULL_LAST);
    // Frame completes at mid-stop, so back-to-back frames are never missed.
    assign w_done = sample_tick && (r_state == S_STOP) && w_full;
`ifdef UART_RX_PARITY_EN
    assign w_frame_bad = ~w_rxs | r_par_err;
`else
    assign w_frame_bad = ~w_rxs;
`endif

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = r_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tcnt        <= '0;
            r_bcnt        <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err     <= 1'b0;
`endif
        end else begin
            if (sample_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rxs) begin
                            r_state <= S_START;
                            r_tcnt  <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (w_half) begin
                            // Line back high at start centre: glitch, not a frame.
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_DATA;
                                r_tcnt  <= '0;
                                r_bcnt  <= '0;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + T_ONE;
                        end
                    end
                    S_DATA: begin
                        if (w_full) begin
                            r_tcnt  <= '0;
                            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            if (r_bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bcnt <= r_bcnt + B_ONE;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + T_ONE;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (w_full) begin
                            r_tcnt    <= '0;
                            r_par_err <= w_rxs ^ (^r_shift);
                            r_state   <= S_STOP;
                        end else begin
                            r_tcnt <= r_tcnt + T_ONE;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_full) begin
                            r_tcnt  <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_tcnt <= r_tcnt + T_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            if (w_done) begin
                r_rx_data     <= r_shift;
                r_rx_valid    <= 1'b1;
                r_frame_err   <= w_frame_bad;
                // An ack on the completion cycle consumes the old byte.
                r_overrun_err <= r_rx_valid & ~rx_ack;
            end else if (rx_ack && r_rx_valid) begin
                r_rx_valid    <= 1'b0;
                r_overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_osr.md
# uart_rx_osr

UART receiver for the echo path, the consumer of the oversampled baud tick produced by the baud-rate generator. Synchronises the serial input and detects the start bit on the oversampling grid. Samples each bit at its centre and presents the received byte to the echo logic over a valid/ack handshake, with frame and overrun error flags.

## Interface
Parameters:
- OSR, 16, oversampling ratio (sample_tick pulses per bit); even, ≥4
- DATA_BITS, 8, data bits per frame (5..8)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  reset, synchronous, active-low
- sample_tick  input  1  one-clk-wide enable at OSR × baud; all bit timing advances only on cycles with sample_tick=1
- rxd  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received byte, LSB = first bit on the line
- rx_valid  output  1  rx_data holds an unacknowledged byte
- rx_ack  input  1  one-clk pulse from the consumer; clears rx_valid
- frame_err  output  1  stop bit sampled low on the last frame
- overrun_err  output  1  a frame completed while rx_valid was already 1
- busy  output  1  state ≠ IDLE

## Operation
- rxd passes through a 2-flop synchroniser, both flops reset to 1. This adds 2 clk of latency. Only the synchronised signal rxs is used.
- Tick counter tcnt is ceil(log2(OSR)) bits wide. Bit counter bcnt is ceil(log2(DATA_BITS)) bits wide. Both advance only on sample_tick.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - On a tick with rxs=0, go to START and set tcnt=0.
- START:
  - On the tick where tcnt reaches OSR/2−1, sample rxs (centre of start bit).
  - If rxs=1, treat it as a false start and return to IDLE.
  - Otherwise go to DATA with tcnt=0 and bcnt=0.
- DATA:
  - On each tick where tcnt=OSR−1, shift rxs into shift[DATA_BITS−1] (right shift; LSB first) and wrap tcnt to 0.
  - After the sample with bcnt=DATA_BITS−1, go to PARITY if compiled in, else STOP.
- PARITY (only with the macro): sample after OSR ticks, then go to STOP.
- STOP:
  - Sample after OSR ticks and go to IDLE on the same edge.
  - On that edge, load rx_data←shift and set rx_valid=1.
  - On that edge, set frame_err = ~rxs, plus the parity mismatch term when compiled in.
- Handshake and error flags:
  - rx_ack with rx_valid=1 clears rx_valid and overrun_err on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - If a frame completes while rx_valid=1 and rx_ack is not asserted that cycle, rx_data is overwritten, rx_valid stays 1 and overrun_err is set to 1.
  - If a frame completes on the same cycle as rx_ack, the new byte loads, rx_valid stays 1 and overrun_err is cleared.
  - frame_err updates at every frame completion and is not cleared by rx_ack.
  - On a framing error, the byte is still delivered.
- Line behaviour:
  - rxs low in IDLE right after STOP (line held low or break) starts a new frame on the next tick. No lock-up.
  - Glitches shorter than OSR/2 ticks are rejected by the start-centre check.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0, state=IDLE, counters=0, shift=0.
- Reset asserted mid-frame aborts the frame on the next edge; no partial byte is delivered.
- Start detection: first tick with rxs=0, which is 2 clk plus up to 1 tick after the rxd falling edge.
- Sample points fall OSR/2 + k·OSR ticks after start detection, for k = 1..DATA_BITS (data) and k = DATA_BITS+1 (stop). With parity, data stays k = 1..DATA_BITS, parity is k = DATA_BITS+1 and stop moves to k = DATA_BITS+2.
- rx_valid rises on the clk edge of the stop-sample tick, with no extra delay.
- busy deasserts on that same edge.
- rx_valid falls on the edge where rx_ack is sampled high.
- Ticks missing, or sample_tick held at 0, freeze all counters and the state.
- Throughput: back-to-back frames with a single stop bit are accepted, because the receiver returns to IDLE at mid-stop.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present and expects even parity over the data bits.
  - A mismatch ORs into frame_err.
  - Frame length is 1+DATA_BITS+1+1 bits.
- Not defined:
  - No PARITY state; frame length is 1+DATA_BITS+1 bits.
  - No parity logic is synthesised.

## Test plan
- Reset: hold reset_n=0 for 3 clk with rxd=1 -> all outputs 0, busy=0. Release, then send no frame -> outputs stay 0.
- Single frame: OSR=16, send 0xA5 (8N1) -> rx_data=0xA5 and rx_valid=1 at the stop-sample tick, frame_err=0. rx_ack -> rx_valid=0 on the next edge.
- False start: rxd low for 5 ticks, then high -> return to IDLE, busy=0 within 8 ticks, rx_valid stays 0.
- Framing error: send 0x3C with the stop bit held 0 -> rx_data=0x3C, rx_valid=1, frame_err=1. Next frame 0x55 with a good stop bit -> frame_err=0.
- Overrun and simultaneity: send 0x11 then 0x22 back-to-back without ack -> rx_data=0x22, overrun_err=1. Repeat with rx_ack on the completion cycle of 0x22 -> rx_valid=1, overrun_err=0.
- Mid-frame reset and parity: reset after 4 data bits -> no rx_valid, then a clean receive of 0x81. With UART_RX_PARITY_EN, 0x07 with parity bit 0 -> frame_err=1; with parity bit 1 -> frame_err=0.
